cpu24_ifetch: RTL and testbench

CPU24_IFETCH -- requirements
Module: cpu24_ifetch

---
 rtl/cpu24_pkg.sv | 25 ++
 rtl/cpu24_ifetch_fifo.sv | 61 ++++++
 rtl/cpu24_ifetch.sv | 144 ++++++++++++++
 tb/tb_cpu24_ifetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu24_pkg.sv
// Shared definitions for the cpu24 instruction-fetch slice: word width,
// fetch FSM states, default reset PC and the prefetch-queue entry layout.
package cpu24_pkg;

   localparam int WORD_W = 24;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 24'h000000;

   // IDLE lasts exactly one cycle after reset; DRAIN discards stale responses
   // left in flight by a redirect.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // One prefetch-queue entry: the instruction word and the address it came from.
   typedef struct packed {
      word_t data;
      word_t pc;
   } qent_t;

endpackage

// File: rtl/cpu24_ifetch_fifo.sv
// Prefetch queue for cpu24_ifetch: power-of-two circular buffer with a
// synchronous flush that empties it in one cycle. The caller guarantees it
// never pushes into a full queue; the guard here only keeps the count sane.
module cpu24_ifetch_fifo #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [ENTRY_W-1:0]       push_data,
   input  logic                     pop,
   output logic [ENTRY_W-1:0]       head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (count != CNT_W'(DEPTH));
   assign head    = mem[rd_ptr];

   // Entry storage: written on push, never reset.
   // NOTE: the storage array has no reset; validity is tracked by the pointers
   // and count alone, which keeps the array a plain RAM with no reset fan-out.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Read/write pointers and occupancy; flush wins over push and pop.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/cpu24_ifetch.sv
// cpu24 instruction fetch unit: issues sequential word reads, buffers the
// in-order responses in a prefetch queue and hands them to decode. A redirect
// flushes the queue and discards responses still in flight.
// Optional build macro CPU24_IFETCH_PERF_EN adds saturating perf counters
// perf_fetch (accepted requests) and perf_stall (FETCH cycles, queue empty).
module cpu24_ifetch
   import cpu24_pkg::*;
#(
   parameter int    DEPTH    = 4,
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redir_valid,
   input  logic [WORD_W-1:0] redir_pc,
   output logic              mreq_valid,
   output logic [WORD_W-1:0] mreq_addr,
   input  logic              mreq_ready,
   input  logic              mrsp_valid,
   input  logic [WORD_W-1:0] mrsp_data,
   output logic              dec_valid,
   output logic [WORD_W-1:0] dec_instr,
   output logic [WORD_W-1:0] dec_pc,
   input  logic              dec_ready
`ifdef CPU24_IFETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch,
   output logic [31:0]       perf_stall
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_next;
   word_t            fetch_pc;
   word_t            rsp_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] outstanding_next;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] q_count;
   logic             q_empty;
   qent_t            q_head;
   qent_t            push_ent;
   logic             req_fire;
   logic             rsp_seen;
   logic             rsp_push;
   logic             dec_fire;

   // Handshake decode: request gating, response routing and decode handoff.
   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      mreq_valid = 1'b0;
      if (state == ST_FETCH) begin
         // Reserve a slot for every outstanding request so responses always fit.
         mreq_valid = (int'(q_count) + int'(outstanding)) < DEPTH;
      end
      req_fire         = mreq_valid & mreq_ready;
      rsp_seen         = mrsp_valid & (outstanding != '0);
      rsp_push         = rsp_seen & ~redir_valid & (state == ST_FETCH);
      dec_valid        = ~q_empty & ~redir_valid;
      dec_fire         = dec_valid & dec_ready;
      outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_seen);
      push_ent         = '{data: mrsp_data, pc: rsp_pc};
      dec_instr        = q_empty ? '0 : q_head.data;
      dec_pc           = q_empty ? '0 : q_head.pc;
   end

   assign mreq_addr = fetch_pc;

   // Next-state logic; a redirect overrides the per-state transitions.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  state_next = ST_FETCH;
         ST_FETCH: state_next = ST_FETCH;
         ST_DRAIN: if (rsp_seen && discard == CNT_W'(1)) state_next = ST_FETCH;
         default:  state_next = ST_IDLE;
      endcase
      if (redir_valid) begin
         state_next = (outstanding_next != '0) ? ST_DRAIN : ST_FETCH;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // PCs, in-flight request count and stale-response discard count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redir_valid) begin
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
            // Everything still in flight after this cycle belongs to the old stream.
            discard  <= outstanding_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 24'd1;
            if (rsp_push) rsp_pc   <= rsp_pc + 24'd1;
            if (state == ST_DRAIN && rsp_seen) discard <= discard - CNT_W'(1);
         end
      end
   end

   cpu24_ifetch_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (2 * WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redir_valid),
      .push      (rsp_push),
      .push_data (push_ent),
      .pop       (dec_fire),
      .head      (q_head),
      .empty     (q_empty),
      .count     (q_count)
   );

`ifdef CPU24_IFETCH_PERF_EN
   // Saturating counters: accepted requests and FETCH cycles with nothing queued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch <= '0;
         perf_stall <= '0;
      end else begin
         if (req_fire && perf_fetch != '1) perf_fetch <= perf_fetch + 32'd1;
         if (q_empty && state == ST_FETCH && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`else
   // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_cpu24_ifetch.sv
// Self-checking bench for cpu24_ifetch. A behavioural memory (in-order,
// random latency) and a stream model (epoch-tagged requests, queue of valid
// returned instructions) predict every output each cycle; directed phases
// pin specific sequences with literal values, then a randomized phase runs.
module tb_cpu24_ifetch;
   import cpu24_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_valid;
   logic [23:0] redir_pc;
   logic        mreq_valid;
   logic [23:0] mreq_addr;
   logic        mreq_ready;
   logic        mrsp_valid;
   logic [23:0] mrsp_data;
   logic        dec_valid;
   logic [23:0] dec_instr;
   logic [23:0] dec_pc;
   logic        dec_ready;
`ifdef CPU24_IFETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
`endif

   cpu24_ifetch #(.DEPTH(DEPTH), .RESET_PC(24'h000000)) dut (
      .clk         (clk),
      .rst         (rst),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .mreq_valid  (mreq_valid),
      .mreq_addr   (mreq_addr),
      .mreq_ready  (mreq_ready),
      .mrsp_valid  (mrsp_valid),
      .mrsp_data   (mrsp_data),
      .dec_valid   (dec_valid),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .dec_ready   (dec_ready)
`ifdef CPU24_IFETCH_PERF_EN
      ,
      .perf_fetch  (perf_fetch),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [23:0] pc;
      logic [23:0] instr;
   } ent_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // stimulus knobs
   logic        s_rst_n    = 1'b0;
   logic        s_redir    = 1'b0;
   logic [23:0] s_redir_pc = '0;
   logic        s_mready   = 1'b1;
   logic        s_dready   = 1'b1;
   int          lat_min    = 1;
   int          lat_max    = 1;
   int          hold_pct   = 0;

   // model state
   req_t        pend[$];
   ent_t        mq[$];
   logic [23:0] exp_fpc   = 24'h000000;
   int          epoch     = 0;
   bit          was_reset = 1'b1;
   int          acc_count = 0;
   int          drop_count = 0;

   // decode-transfer log for directed checks
   logic [23:0] log_pc[$];
   logic [23:0] log_instr[$];
   int          log_cyc[$];

   function automatic logic [23:0] mem_word(input logic [23:0] a);
      return {a[11:0], a[23:12]} ^ 24'hA5C3E1;
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_log();
      log_pc.delete();
      log_instr.delete();
      log_cyc.delete();
   endtask

   // Outputs predicted from the model state as it stood before this cycle's events.
   task automatic compare();
      int stale;
      bit exp_mv;
      bit exp_dv;
      if (was_reset) begin
         check("rst_mreq_valid", mreq_valid, 0);
         check("rst_dec_valid",  dec_valid,  0);
         check("rst_mreq_addr",  mreq_addr,  48'h000000);
         check("rst_dec_instr",  dec_instr,  0);
         check("rst_dec_pc",     dec_pc,     0);
      end else begin
         stale = 0;
         foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
         exp_mv = (stale == 0) && (mq.size() + pend.size() < DEPTH);
         exp_dv = (mq.size() > 0) && !redir_valid;
         check("mreq_valid", mreq_valid, exp_mv);
         if (exp_mv) check("mreq_addr", mreq_addr, exp_fpc);
         check("dec_valid", dec_valid, exp_dv);
         if (exp_dv) begin
            check("dec_pc",    dec_pc,    mq[0].pc);
            check("dec_instr", dec_instr, mq[0].instr);
         end
      end
   endtask

   // Apply this cycle's events to memory and stream model.
   task automatic update();
      req_t h;
      bit   acc;
      acc = mreq_valid & mreq_ready;
      if (!rst) begin
         pend.delete();
         mq.delete();
         exp_fpc   = 24'h000000;
         epoch++;
         was_reset = 1'b1;
      end else begin
         was_reset = 1'b0;
         if (dec_valid && dec_ready) begin
            log_pc.push_back(dec_pc);
            log_instr.push_back(dec_instr);
            log_cyc.push_back(cyc);
         end
         if (mq.size() > 0 && !redir_valid && dec_ready) mq.delete(0);
         if (mrsp_valid) begin
            h = pend.pop_front();
            if (!redir_valid && h.epoch == epoch) mq.push_back('{pc: h.addr, instr: mem_word(h.addr)});
            else drop_count++;
         end
         if (acc) begin
            acc_count++;
            pend.push_back('{addr: mreq_addr, epoch: epoch,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
         end
         if (redir_valid) begin
            exp_fpc = redir_pc;
            mq.delete();
            epoch++;
         end else if (acc) begin
            exp_fpc = exp_fpc + 24'd1;
         end
         check("inflight_bound", pend.size() <= DEPTH, 1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rst         = s_rst_n;
      redir_valid = s_rst_n & s_redir;
      redir_pc    = s_redir_pc;
      mreq_ready  = s_mready;
      dec_ready   = s_dready;
      mrsp_valid  = 1'b0;
      mrsp_data   = '0;
      if (s_rst_n && pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99)) >= hold_pct) begin
         mrsp_valid = 1'b1;
         mrsp_data  = mem_word(pend[0].addr);
      end
      @(negedge clk);
      compare();
      update();
   endtask

   task automatic do_reset();
      s_rst_n = 1'b0;
      s_redir = 1'b0;
      step();
      step();
      s_rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0; redir_valid = 1'b0; redir_pc = '0; mreq_ready = 1'b0;
      mrsp_valid = 1'b0; mrsp_data = '0; dec_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then sequential fetch with a 1-cycle memory.
      do_reset();
      lat_min = 1; lat_max = 1; hold_pct = 0; s_mready = 1'b1; s_dready = 1'b1;
      clear_log();
      n = cyc + 1;
      repeat (12) step();
      check("seq_count", log_pc.size() >= 6, 1);
      if (log_pc.size() >= 6) begin
         check("seq_fill_latency", log_cyc[0] - n, 3);
         check("seq_first_instr", log_instr[0], 24'hA5C3E1);
         for (int i = 0; i < 6; i++) begin
            check("seq_pc", log_pc[i], 48'(i));
            check("seq_one_per_cycle", log_cyc[i] - log_cyc[0], 48'(i));
         end
      end

      // Decode stalled: exactly DEPTH requests, then the request line idles.
      do_reset();
      s_dready = 1'b0;
      acc_count = 0;
      repeat (10) step();
      check("stall_issued", acc_count, 4);
      check("stall_mreq_idle", mreq_valid, 0);
      s_dready = 1'b1;
      step();
      step();
      check("stall_resume", mreq_valid, 1);

      // Redirect with 3 requests in flight: all 3 dropped, stream restarts at 0x100.
      do_reset();
      lat_min = 6; lat_max = 6;
      n = 0;
      while (pend.size() < 3 && n < 20) begin step(); n++; end
      check("redir3_setup", pend.size(), 3);
      clear_log();
      drop_count = 0;
      s_mready = 1'b0; s_redir = 1'b1; s_redir_pc = 24'h000100;
      step();
      s_mready = 1'b1; s_redir = 1'b0; lat_min = 1; lat_max = 1;
      n = 0;
      while (log_pc.size() < 2 && n < 30) begin step(); n++; end
      check("redir3_dropped", drop_count, 3);
      check("redir3_count", log_pc.size() >= 2, 1);
      if (log_pc.size() >= 2) begin
         check("redir3_pc0", log_pc[0], 24'h000100);
         check("redir3_pc1", log_pc[1], 24'h000101);
         check("redir3_instr0", log_instr[0], mem_word(24'h000100));
      end

      // Redirect coinciding with a response and a ready decoder.
      n = 0;
      while (!(pend.size() > 0 && pend[0].due <= cyc + 1 && mq.size() > 0) && n < 20) begin step(); n++; end
      clear_log();
      s_redir = 1'b1; s_redir_pc = 24'h0ABCDE;
      step();
      s_redir = 1'b0;
      check("coinc_rsp_seen", mrsp_valid, 1);
      check("coinc_dec_valid", dec_valid, 0);
      check("coinc_no_xfer", log_pc.size(), 0);
      repeat (8) step();
      check("coinc_count", log_pc.size() >= 1, 1);
      if (log_pc.size() >= 1) check("coinc_next_pc", log_pc[0], 24'h0ABCDE);

      // Redirect near the top of the address space: PC wraps to zero.
      clear_log();
      s_redir = 1'b1; s_redir_pc = 24'hFFFFFE;
      step();
      s_redir = 1'b0;
      repeat (10) step();
      check("wrap_count", log_pc.size() >= 3, 1);
      if (log_pc.size() >= 3) begin
         check("wrap_pc0", log_pc[0], 24'hFFFFFE);
         check("wrap_pc1", log_pc[1], 24'hFFFFFF);
         check("wrap_pc2", log_pc[2], 24'h000000);
      end

      // Reset asserted while draining stale responses.
      lat_min = 6; lat_max = 6;
      n = 0;
      while (pend.size() < 2 && n < 20) begin step(); n++; end
      s_mready = 1'b0; s_redir = 1'b1; s_redir_pc = 24'h000200;
      step();
      s_redir = 1'b0;
      step();
      check("drain_idle", mreq_valid, 0);
      s_rst_n = 1'b0;
      step();
      s_rst_n = 1'b1; s_mready = 1'b1; lat_min = 1; lat_max = 1;
      step();
      check("rstdrain_mreq_valid", mreq_valid, 0);
      check("rstdrain_dec_valid", dec_valid, 0);
      check("rstdrain_mreq_addr", mreq_addr, 24'h000000);
      check("rstdrain_dec_pc", dec_pc, 24'h000000);
      check("rstdrain_dec_instr", dec_instr, 24'h000000);
      step();
      check("rstdrain_fetch_resumes", mreq_valid, 1);
      check("rstdrain_fetch_addr", mreq_addr, 24'h000000);

      // Randomized traffic.
      lat_min = 1; lat_max = 4; hold_pct = 20;
      for (int i = 0; i < 4000; i++) begin
         s_mready = ($urandom_range(99) < 70);
         s_dready = ($urandom_range(99) < 60);
         s_redir  = ($urandom_range(99) < 4);
         s_redir_pc = ($urandom_range(1) == 0) ? 24'($urandom) : (24'hFFFFF0 + 24'($urandom_range(15)));
         s_rst_n  = ($urandom_range(499) != 0);
         step();
      end
      s_rst_n = 1'b1; s_redir = 1'b0;
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
